// File: rtl/power_kernel_pkg.sv
// Shared types and helpers for the power_kernel_pipe slice: monitor FSM states,
// the 4-input kernel, popcount and the sample-counter width.
package power_kernel_pkg;

  typedef enum logic [1:0] {StIdle, StAccum, StDump} mon_state_e;

  localparam int unsigned MaxCh = 64;

  function automatic logic kernel(input logic a, input logic b, input logic c, input logic d);
    return ~b & c & ~((~a & d) ^ (c & d));
  endfunction

  function automatic logic [6:0] popcount(input logic [MaxCh-1:0] v);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < MaxCh; i++) begin
      n = n + 7'(v[i]);
    end
    return n;
  endfunction

  // Wide enough to hold the value WIN itself.
  function automatic int unsigned samp_w(input int unsigned win);
    return $clog2(win + 1);
  endfunction

endpackage

// File: rtl/power_kernel_cell.sv
// Combinational single-channel power-benchmark kernel.
module power_kernel_cell
  import power_kernel_pkg::*;
(
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  input  logic d_i,
  output logic y_o
);

  assign y_o = kernel(a_i, b_i, c_i, d_i);

endmodule

// File: rtl/power_kernel_pipe.sv
// Two-stage multi-channel kernel pipeline with an optional per-window toggle
// monitor, built only when POWER_KERNEL_ACTIVITY_EN is defined.
module power_kernel_pipe
  import power_kernel_pkg::*;
#(
  parameter int unsigned CH    = 4,
  parameter int unsigned WIN   = 256,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [CH-1:0]    a,
  input  logic [CH-1:0]    b,
  input  logic [CH-1:0]    c,
  input  logic [CH-1:0]    d,
  output logic             out_valid,
  output logic [CH-1:0]    y,
  output logic             win_valid,
  output logic [CNT_W-1:0] win_count
);

  logic          v1_q, v1_d;
  logic [CH-1:0] a1_q, a1_d, b1_q, b1_d, c1_q, c1_d, d1_q, d1_d;
  logic [CH-1:0] y_k;
  logic          out_valid_q, out_valid_d;
  logic [CH-1:0] y_q, y_d;

  for (genvar i = 0; i < CH; i++) begin : g_cell
    power_kernel_cell u_cell (
      .a_i(a1_q[i]),
      .b_i(b1_q[i]),
      .c_i(c1_q[i]),
      .d_i(d1_q[i]),
      .y_o(y_k[i])
    );
  end

  always_comb begin
    v1_d        = in_valid;
    a1_d        = a;
    b1_d        = b;
    c1_d        = c;
    d1_d        = d;
    out_valid_d = v1_q;
    y_d         = y_k;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q        <= 1'b0;
      a1_q        <= '0;
      b1_q        <= '0;
      c1_q        <= '0;
      d1_q        <= '0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
    end else begin
      v1_q        <= v1_d;
      a1_q        <= a1_d;
      b1_q        <= b1_d;
      c1_q        <= c1_d;
      d1_q        <= d1_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;

`ifdef POWER_KERNEL_ACTIVITY_EN
  localparam int unsigned IW = $clog2(CH + 1);
  localparam int unsigned SW = samp_w(WIN);
  localparam int unsigned AW = ((CNT_W > IW) ? CNT_W : IW) + 1;
  localparam logic [CNT_W-1:0] AccMax = '1;

  mon_state_e       state_q, state_d;
  logic [CNT_W-1:0] acc_q, acc_d, acc_base, acc_sat;
  logic [SW-1:0]    samples_q, samples_d, samples_inc;
  logic [CH-1:0]    ref_q, ref_d;
  logic             win_valid_q, win_valid_d;
  logic [CNT_W-1:0] win_count_q, win_count_d;
  logic [IW-1:0]    inc;
  logic [AW-1:0]    sum;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    samples_d   = samples_q;
    ref_d       = ref_q;
    win_valid_d = 1'b0;
    win_count_d = win_count_q;

    inc         = IW'(popcount(MaxCh'(y_q ^ ref_q)));
    // A result arriving during DUMP opens the next window from zero.
    acc_base    = (state_q == StDump) ? '0 : acc_q;
    sum         = AW'(acc_base) + AW'(inc);
    acc_sat     = (sum > AW'(AccMax)) ? AccMax : sum[CNT_W-1:0];
    samples_inc = samples_q + SW'(1);

    case (state_q)
      StIdle: begin
        if (out_valid_q) begin
          ref_d     = y_q;
          acc_d     = '0;
          samples_d = SW'(1);
          state_d   = StAccum;
        end
      end
      StAccum: begin
        if (out_valid_q) begin
          ref_d     = y_q;
          acc_d     = acc_sat;
          samples_d = samples_inc;
          if (samples_inc == SW'(WIN)) begin
            state_d = StDump;
          end
        end
      end
      StDump: begin
        state_d = StAccum;
        if (out_valid_q) begin
          ref_d     = y_q;
          acc_d     = acc_sat;
          samples_d = SW'(1);
        end else begin
          acc_d     = '0;
          samples_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_d == StDump) begin
      win_valid_d = 1'b1;
      win_count_d = acc_d;
    end

    if (clr) begin
      state_d     = StIdle;
      acc_d       = '0;
      samples_d   = '0;
      ref_d       = '0;
      win_valid_d = 1'b0;
      win_count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      samples_q   <= '0;
      ref_q       <= '0;
      win_valid_q <= 1'b0;
      win_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      samples_q   <= samples_d;
      ref_q       <= ref_d;
      win_valid_q <= win_valid_d;
      win_count_q <= win_count_d;
    end
  end

  assign win_valid = win_valid_q;
  assign win_count = win_count_q;
`else
  logic unused_clr;
  assign unused_clr = clr;
  assign win_valid  = 1'b0;
  assign win_count  = '0;
`endif

endmodule

// File: tb/tb_power_kernel_pipe.sv
// Directed bench for power_kernel_pipe (CH=4, WIN=4) plus a CNT_W=3 instance
// sharing the same stimulus for the saturation scenario.
module tb_power_kernel_pipe;
  import power_kernel_pkg::*;

  logic        clk = 1'b0;
  logic        rst, clr, in_valid;
  logic [3:0]  a, b, c, d;
  logic        out_valid, win_valid;
  logic [3:0]  y;
  logic [15:0] win_count;
  logic        out_valid_s, win_valid_s;
  logic [3:0]  y_s;
  logic [2:0]  win_count_s;

  int n_checks = 0;
  int n_fail   = 0;
  int vres, np, nps;
  int pos[8];
  int val[8];
  int vals[8];

  power_kernel_pipe #(.CH(4), .WIN(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid),
    .a(a), .b(b), .c(c), .d(d),
    .out_valid(out_valid), .y(y), .win_valid(win_valid), .win_count(win_count)
  );

  power_kernel_pipe #(.CH(4), .WIN(4), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid),
    .a(a), .b(b), .c(c), .d(d),
    .out_valid(out_valid_s), .y(y_s), .win_valid(win_valid_s), .win_count(win_count_s)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Advance one cycle and log window pulses against the valid results seen before them.
  task automatic tick();
    @(posedge clk);
    #1;
    if (win_valid) begin
      if (np < 8) begin
        pos[np] = vres;
        val[np] = int'(win_count);
      end
      np++;
    end
    if (win_valid_s) begin
      if (nps < 8) vals[nps] = int'(win_count_s);
      nps++;
    end
    if (out_valid) vres++;
  endtask

  task automatic clear_log();
    vres = 0;
    np   = 0;
    nps  = 0;
    for (int i = 0; i < 8; i++) begin
      pos[i]  = -1;
      val[i]  = -1;
      vals[i] = -1;
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    clr      = 1'b0;
    in_valid = 1'b0;
    a = '0; b = '0; c = '0; d = '0;
    #2;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_log();
  endtask

  // c drives y directly when a=b=d=0.
  task automatic drive(input logic v, input logic [3:0] cv);
    in_valid = v;
    a = '0; b = '0; d = '0;
    c = cv;
    tick();
  endtask

  task automatic stream(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, (i % 2 == 0) ? 4'hF : 4'h0);
      for (int g = 0; g < gap; g++) drive(1'b0, 4'h5);
    end
    for (int t = 0; t < 6; t++) drive(1'b0, 4'h0);
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 6; i++) drive(1'b1, (i % 2 == 0) ? 4'hF : 4'h0);
    n_checks++;
    if (out_valid !== 1'b1 || y !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_pre: out_valid=%b y=%h expected 1 f", out_valid, y);
    end
    #2;
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || y !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_async_pipe: out_valid=%b y=%h expected 0 0", out_valid, y);
    end
    n_checks++;
    if (win_valid !== 1'b0 || win_count !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_async_win: win_valid=%b win_count=%0d expected 0 0",
               win_valid, win_count);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_log();
`ifdef POWER_KERNEL_ACTIVITY_EN
    n_checks++;
    if (dut.state_q !== StIdle) begin
      n_fail++;
      $display("FAIL reset_fsm: state=%0d expected %0d", dut.state_q, StIdle);
    end
`endif
    drive(1'b1, 4'hF);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_latency1: out_valid=%b expected 0", out_valid);
    end
    drive(1'b0, 4'h0);
    n_checks++;
    if (out_valid !== 1'b1 || y !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_latency2: out_valid=%b y=%h expected 1 f", out_valid, y);
    end
  endtask

  task automatic test_truth();
    logic [3:0] vec[5];
    logic       ex[5];
    logic [3:0] ey;
    vec = '{4'b0010, 4'b0011, 4'b1011, 4'b0111, 4'b1001};
    ex  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    do_reset();
    for (int n = 0; n < 7; n++) begin
      in_valid = (n < 5);
      for (int j = 0; j < 4; j++) begin
        a[j] = vec[(n + j) % 5][3];
        b[j] = vec[(n + j) % 5][2];
        c[j] = vec[(n + j) % 5][1];
        d[j] = vec[(n + j) % 5][0];
      end
      tick();
      if (n == 0 || n == 6) begin
        n_checks++;
        if (out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL truth_idle_%0d: out_valid=%b expected 0", n, out_valid);
        end
      end else begin
        for (int j = 0; j < 4; j++) ey[j] = ex[(n - 1 + j) % 5];
        n_checks++;
        if (out_valid !== 1'b1 || y !== ey) begin
          n_fail++;
          $display("FAIL truth_%0d: out_valid=%b y=%b expected 1 %b", n - 1, out_valid, y, ey);
        end
      end
    end
  endtask

  task automatic check_windows(input string name, input int gap);
    do_reset();
    stream(8, gap);
    n_checks++;
    if (vres !== 8) begin
      n_fail++;
      $display("FAIL %s_results: got %0d expected 8", name, vres);
    end
`ifdef POWER_KERNEL_ACTIVITY_EN
    n_checks++;
    if (np !== 2) begin
      n_fail++;
      $display("FAIL %s_pulses: got %0d expected 2", name, np);
    end
    n_checks++;
    if (pos[0] !== 4 || val[0] !== 12) begin
      n_fail++;
      $display("FAIL %s_win0: after %0d count %0d expected after 4 count 12", name, pos[0], val[0]);
    end
    n_checks++;
    if (pos[1] !== 8 || val[1] !== 16) begin
      n_fail++;
      $display("FAIL %s_win1: after %0d count %0d expected after 8 count 16", name, pos[1], val[1]);
    end
    n_checks++;
    if (win_count !== 16'd16) begin
      n_fail++;
      $display("FAIL %s_hold: win_count=%0d expected 16", name, win_count);
    end
`else
    n_checks++;
    if (np !== 0 || win_count !== 16'h0) begin
      n_fail++;
      $display("FAIL %s_disabled: pulses=%0d win_count=%0d expected 0 0", name, np, win_count);
    end
`endif
  endtask

  task automatic test_window();
    check_windows("window", 0);
  endtask

  task automatic test_bubbles();
    check_windows("bubbles", 1);
  endtask

  task automatic test_saturation();
    do_reset();
    stream(8, 0);
`ifdef POWER_KERNEL_ACTIVITY_EN
    n_checks++;
    if (nps !== 2 || vals[0] !== 7 || vals[1] !== 7) begin
      n_fail++;
      $display("FAIL saturation: pulses=%0d counts %0d %0d expected 2 7 7", nps, vals[0], vals[1]);
    end
`else
    n_checks++;
    if (nps !== 0 || win_count_s !== 3'h0) begin
      n_fail++;
      $display("FAIL saturation_disabled: pulses=%0d count=%0d expected 0 0", nps, win_count_s);
    end
`endif
  endtask

  task automatic test_clr();
    do_reset();
    drive(1'b1, 4'hF);
    drive(1'b1, 4'h0);
    drive(1'b0, 4'h0);
    clr = 1'b1;
    drive(1'b0, 4'h0);
    clr = 1'b0;
    stream(4, 0);
    n_checks++;
    if (vres !== 6) begin
      n_fail++;
      $display("FAIL clr_results: got %0d expected 6", vres);
    end
`ifdef POWER_KERNEL_ACTIVITY_EN
    n_checks++;
    if (np !== 1 || pos[0] !== 6 || val[0] !== 12) begin
      n_fail++;
      $display("FAIL clr_window: pulses=%0d after %0d count %0d expected 1 after 6 count 12",
               np, pos[0], val[0]);
    end
`else
    n_checks++;
    if (np !== 0) begin
      n_fail++;
      $display("FAIL clr_disabled: pulses=%0d expected 0", np);
    end
`endif
  endtask

  initial begin
    clear_log();
    test_reset();
    test_truth();
    test_window();
    test_bubbles();
    test_saturation();
    test_clr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
